// File: rtl/uc_pkg.sv
// Shared types and default sizing for the unit-clause broadcast path.
// Pure declarations: no logic, no latency, no flow control.
package uc_pkg;
  localparam int UC_LENGTH  = 1024;
  localparam int NUM_ENGINE = 4;
  localparam int LIT_W      = $clog2(UC_LENGTH);
  localparam int DEPTH      = 8;
  localparam int CNT_W      = 16;

  typedef logic signed [LIT_W-1:0] lit_t;
  typedef enum logic [1:0] {IDLE, RUN, HALT} uc_bc_state_t;
endpackage

// File: rtl/uc_rx_fifo.sv
// Per-engine receive FIFO with show-ahead head; write visible on the next cycle.
// Full/empty come from registered occupancy; flush wins over any read or write.
module uc_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   occ;
  logic          do_wr, do_rd;

  assign empty = (occ == '0);
  assign full  = (occ == FULL_OCC);
  assign do_wr = wr && !full && !flush;
  assign do_rd = rd && !empty && !flush;
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      // simultaneous read and write leaves occupancy unchanged
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/uc_broadcaster.sv
// Pops unit-clause literals and copies each into every engine FIFO (visible next cycle).
// Pop stalls while any engine FIFO is full; a conflict halts and flushes all FIFOs.
module uc_broadcaster #(
  parameter int NUM_ENGINE = uc_pkg::NUM_ENGINE,
  parameter int LIT_W      = uc_pkg::LIT_W,
  parameter int DEPTH      = uc_pkg::DEPTH,
  parameter int CNT_W      = uc_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          uca_empty,
  input  logic signed [LIT_W-1:0]       uca_lit,
  input  logic                          uca_conflict,
  output logic                          uca_pop,
  output logic [NUM_ENGINE-1:0]         eng_valid,
  output logic [NUM_ENGINE*LIT_W-1:0]   eng_lit,
  input  logic [NUM_ENGINE-1:0]         eng_rd,
  output logic [CNT_W-1:0]              bc_count,
  output logic                          halted,
  output logic                          err_zero
);
  import uc_pkg::*;

  uc_bc_state_t          state, state_nxt;
  logic [NUM_ENGINE-1:0] full_v, empty_v;
  logic                  flush, lit_zero, wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    uca_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (uca_conflict) state_nxt = HALT;
        else if (start)   state_nxt = RUN;
      end
      RUN: begin
        if (uca_conflict) state_nxt = HALT;
        else              uca_pop = !uca_empty && !(|full_v);
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // flush lands on the edge into HALT and keeps the FIFOs empty afterwards
  assign flush    = (state_nxt == HALT);
  assign lit_zero = (uca_lit == '0);
  assign wr       = uca_pop && !lit_zero;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc_count <= '0;
      err_zero <= 1'b0;
    end else begin
      if (wr)                 bc_count <= bc_count + 1'b1;
      if (uca_pop && lit_zero) err_zero <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_eng
    uc_rx_fifo #(.W(LIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .wr    (wr),
      .wdata (uca_lit),
      .rd    (eng_rd[g]),
      .rdata (eng_lit[g*LIT_W +: LIT_W]),
      .empty (empty_v[g]),
      .full  (full_v[g])
    );
  end

  assign eng_valid = ~empty_v;
endmodule

// File: tb/tb_uc_broadcaster.sv
// Directed bench: behavioural arbiter queue, per-engine consume log, hand-computed expectations.
module tb_uc_broadcaster;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        uca_empty = 1'b1;
  logic [9:0]  uca_lit = '0;
  logic        uca_conflict = 1'b0;
  logic        uca_pop;
  logic [3:0]  eng_valid;
  logic [39:0] eng_lit;
  logic [3:0]  eng_rd = '0;
  logic [15:0] bc_count;
  logic        halted;
  logic        err_zero;

  int n_chk  = 0;
  int n_fail = 0;
  int pops   = 0;
  int base   = 0;

  logic [9:0] q [$];
  logic [9:0] got [4][$];

  uc_broadcaster dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .uca_empty    (uca_empty),
    .uca_lit      (uca_lit),
    .uca_conflict (uca_conflict),
    .uca_pop      (uca_pop),
    .eng_valid    (eng_valid),
    .eng_lit      (eng_lit),
    .eng_rd       (eng_rd),
    .bc_count     (bc_count),
    .halted       (halted),
    .err_zero     (err_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] lane(input int i);
    return eng_lit[i*10 +: 10];
  endfunction

  function automatic logic [9:0] g(input int e, input int k);
    return (got[e].size() > k) ? got[e][k] : 10'h2AA;
  endfunction

  task automatic refresh;
    uca_empty = (q.size() == 0);
    uca_lit   = uca_empty ? 10'd0 : q[0];
  endtask

  task automatic push(input logic [9:0] l);
    q.push_back(l);
    refresh();
  endtask

  // The arbiter queue and the consume log both follow the pre-edge handshake values.
  task automatic tick;
    @(posedge clk);
    if (uca_pop) begin
      pops++;
      if (q.size() > 0) void'(q.pop_front());
    end
    for (int i = 0; i < 4; i++)
      if (rst && eng_rd[i] && eng_valid[i]) got[i].push_back(lane(i));
    #1;
    refresh();
    #1;
  endtask

  task automatic clear_got;
    for (int i = 0; i < 4; i++) got[i].delete();
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    eng_rd = 4'hF;
    while ((eng_valid != 4'h0 || q.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    check("drain_done", 32'(n < maxc), 32'd1);
    eng_rd = 4'h0;
  endtask

  task automatic check_seq(input int e, input int first, input int cnt);
    check($sformatf("seq%0d_len", e), 32'(got[e].size()), 32'(cnt));
    for (int k = 0; k < cnt; k++)
      check($sformatf("seq%0d_%0d", e, k), 32'(g(e, k)), 32'(first + k));
  endtask

  initial begin
    #2;
    check("rst_pop", 32'(uca_pop), 32'd0);
    check("rst_valid", 32'(eng_valid), 32'd0);
    check("rst_lit", eng_lit[31:0], 32'd0);
    check("rst_cnt", 32'(bc_count), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);
    check("rst_errz", 32'(err_zero), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // basic broadcast of +5, -7, +3
    push(10'd5); push(10'(-7)); push(10'd3);
    check("idle_no_pop", 32'(uca_pop), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check("t1_pops", 32'(pops), 32'd3);
    check("t1_cnt", 32'(bc_count), 32'd3);
    check("t1_valid", 32'(eng_valid), 32'hF);
    drain(20);
    for (int e = 0; e < 4; e++) begin
      check("t1_len", 32'(got[e].size()), 32'd3);
      check("t1_l0", 32'(g(e, 0)), 32'h005);
      check("t1_l1", 32'(g(e, 1)), 32'h3F9);
      check("t1_l2", 32'(g(e, 2)), 32'h003);
    end

    // engine 2 stalls: FIFO 2 fills and blocks the pop
    clear_got();
    base = pops;
    eng_rd = 4'b1011;
    for (int k = 1; k <= 10; k++) push(10'(k));
    repeat (12) tick();
    check("t2_pops8", 32'(pops - base), 32'd8);
    check("t2_stall", 32'(uca_pop), 32'd0);
    check("t2_qnonempty", 32'(uca_empty), 32'd0);
    check("t2_head2", 32'(lane(2)), 32'd1);
    eng_rd[2] = 1'b1; tick(); eng_rd[2] = 1'b0;
    repeat (6) tick();
    check("t2_pops9", 32'(pops - base), 32'd9);
    check("t2_stall2", 32'(uca_pop), 32'd0);
    drain(40);
    check_seq(0, 1, 10);
    check_seq(2, 1, 10);
    check("t2_cnt", 32'(bc_count), 32'd13);

    // simultaneous write and read at occupancy 1 and 7
    clear_got();
    push(10'd20); tick();
    check("t3_occ1_head", 32'(lane(0)), 32'd20);
    push(10'd21); eng_rd = 4'b0001; #1;
    check("t3_pop_a", 32'(uca_pop), 32'd1);
    tick();
    check("t3_occ1_valid", 32'(eng_valid[0]), 32'd1);
    check("t3_occ1_new", 32'(lane(0)), 32'd21);
    eng_rd = 4'b1110;
    for (int k = 22; k <= 27; k++) push(10'(k));
    repeat (8) tick();
    check("t3_occ7_head", 32'(lane(0)), 32'd21);
    push(10'd28); eng_rd = 4'hF; #1;
    check("t3_pop_b", 32'(uca_pop), 32'd1);
    tick();
    check("t3_occ7_valid", 32'(eng_valid[0]), 32'd1);
    check("t3_occ7_new", 32'(lane(0)), 32'd22);
    eng_rd = 4'b1110;
    push(10'd29); tick(); tick();
    push(10'd30); #1;
    check("t3_full_stall", 32'(uca_pop), 32'd0);
    drain(40);
    check_seq(0, 20, 11);
    check("t3_cnt", 32'(bc_count), 32'd24);

    // zero literal dropped
    clear_got();
    push(10'd0); push(10'h3FF);
    repeat (4) tick();
    check("t4_errz", 32'(err_zero), 32'd1);
    check("t4_cnt", 32'(bc_count), 32'd25);
    check("t4_valid", 32'(eng_valid), 32'hF);
    check("t4_head", 32'(lane(0)), 32'h3FF);
    drain(20);
    check("t4_len", 32'(got[1].size()), 32'd1);
    check("t4_lit", 32'(g(1, 0)), 32'h3FF);

    // conflict halts and flushes
    push(10'd40); push(10'd41); push(10'd42);
    repeat (4) tick();
    check("t5_valid_pre", 32'(eng_valid), 32'hF);
    push(10'd43); uca_conflict = 1'b1; eng_rd = 4'hF; #1;
    check("t5_pop_conf", 32'(uca_pop), 32'd0);
    tick();
    check("t5_halt", 32'(halted), 32'd1);
    check("t5_flushed", 32'(eng_valid), 32'd0);
    check("t5_pop", 32'(uca_pop), 32'd0);
    check("t5_qnonempty", 32'(uca_empty), 32'd0);
    uca_conflict = 1'b0;
    repeat (3) tick();
    check("t5_valid_post", 32'(eng_valid), 32'd0);
    check("t5_lit_post", eng_lit[31:0], 32'd0);
    check("t5_cnt", 32'(bc_count), 32'd28);
    check("t5_sticky", 32'(halted), 32'd1);
    check("t5_pop_post", 32'(uca_pop), 32'd0);

    // reset mid-broadcast
    eng_rd = 4'h0;
    q.delete(); refresh();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    check("t6_unhalt", 32'(halted), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    push(10'd50); push(10'd0); push(10'd52); push(10'd53);
    repeat (3) tick();
    check("t6_pre_valid", 32'(eng_valid), 32'hF);
    check("t6_pre_cnt", 32'(bc_count), 32'd2);
    check("t6_pre_errz", 32'(err_zero), 32'd1);
    rst = 1'b0; #1;
    check("t6_valid", 32'(eng_valid), 32'd0);
    check("t6_lit", eng_lit[31:0], 32'd0);
    check("t6_cnt", 32'(bc_count), 32'd0);
    check("t6_pop", 32'(uca_pop), 32'd0);
    check("t6_errz", 32'(err_zero), 32'd0);
    check("t6_halt", 32'(halted), 32'd0);
    rst = 1'b1;
    base = pops;
    repeat (4) tick();
    check("t6_idle_pop", 32'(uca_pop), 32'd0);
    check("t6_idle_pops", 32'(pops - base), 32'd0);
    check("t6_idle_valid", 32'(eng_valid), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    check("t6_cnt_after", 32'(bc_count), 32'd1);
    check("t6_valid_after", 32'(eng_valid), 32'hF);
    check("t6_head_after", 32'(lane(3)), 32'd53);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
